axi_protocol_converter_aw_axi3_split: RTL and testbench
=======================================================

Name: axi_protocol_converter_aw_axi3_split

Overview:
AXI4-to-AXI3 write-address stage that sits directly upstream of the W-channel converter.
- Splits each AXI4 AW transaction (AWLEN up to 255) into AXI3 bursts of at most 16 beats.
- Emits one W command (id, length) per AXI3 burst into the W stage's cmd_valid/cmd_id/cmd_length/cmd_ready interface.
- Emits one B command per AXI4 transaction for the response merger.

Parameters:
C_AXI_ID_WIDTH, 1, ID width.
C_AXI_ADDR_WIDTH, 32, address width.
C_SUPPORT_SPLITTING, 1, 1 = split long INCR bursts; 0 = AWLEN[3:0] passed through (upstream guarantees AWLEN<=15).
C_CMD_FIFO_DEPTH_LOG, 2, log2 depth of each of the W and B command FIFOs (min 1).

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
S_AXI_AWID  in  C_AXI_ID_WIDTH  AXI4 id
S_AXI_AWADDR  in  C_AXI_ADDR_WIDTH  start address
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWSIZE  in  3  beat size
S_AXI_AWBURST  in  2  burst type
S_AXI_AWLOCK  in  1  exclusive
S_AXI_AWCACHE  in  4  passthrough
S_AXI_AWPROT  in  3  passthrough
S_AXI_AWVALID  in  1  handshake
S_AXI_AWREADY  out  1  handshake
M_AXI_AWID  out  C_AXI_ID_WIDTH  AXI3 id
M_AXI_AWADDR  out  C_AXI_ADDR_WIDTH  piece address
M_AXI_AWLEN  out  4  piece beats-1
M_AXI_AWSIZE  out  3  copy
M_AXI_AWBURST  out  2  copy
M_AXI_AWLOCK  out  2  {1'b0, lock}
M_AXI_AWCACHE  out  4  copy
M_AXI_AWPROT  out  3  copy
M_AXI_AWVALID  out  1  handshake
M_AXI_AWREADY  in  1  handshake
w_cmd_valid  out  1  W command available
w_cmd_id  out  C_AXI_ID_WIDTH  id of burst
w_cmd_length  out  4  burst beats-1
w_cmd_ready  in  1  W stage pops command
b_cmd_valid  out  1  B command available
b_cmd_id  out  C_AXI_ID_WIDTH  id
b_cmd_repeat  out  4  AXI3 bursts-1 for this transaction
b_cmd_ready  in  1  B stage pops command

Behaviour:
Clock and reset:
- ACLK; ARESET synchronous, active-high.
- Reset clears both FIFOs, piece counter = 0, state = IDLE.
- Reset values: w_cmd_valid = b_cmd_valid = M_AXI_AWVALID = S_AXI_AWREADY = 0.

Split decision:
- need_split = C_SUPPORT_SPLITTING & (AWBURST == INCR) & (AWLEN[7:4] != 0).
- Piece count = AWLEN[7:4]+1 when need_split, else 1.
- Every piece except the last has AWLEN = 15; the last piece has AWLEN = AWLEN[3:0] (when need_split).
- FIXED and WRAP bursts are never split; AWLEN[3:0] passes through.

Address arithmetic:
- Piece 0 address = S_AXI_AWADDR unmodified.
- Piece k>0 address = (S_AXI_AWADDR with low AWSIZE bits cleared) + k*(16 << AWSIZE).
- Computed modulo 2^C_AXI_ADDR_WIDTH and held in a next-address register.

Lock mapping:
- M_AXI_AWLOCK[0] = S_AXI_AWLOCK, except it is forced to 0 on all pieces of a split transaction (exclusive bursts above 16 beats are demoted to normal).

State machine:
- IDLE: piece counter = 0.
- SPLIT: piece counter > 0; entered after a non-final piece handshake.
- Returns to IDLE when the final piece handshakes.

Handshakes and command pushes:
- M_AXI_AWVALID = S_AXI_AWVALID & ~wfifo_full & ~(piece==0 & bfifo_full).
- Both FIFOs fill only on this block's own pushes, so VALID never deasserts once asserted.
- S_AXI_AWREADY = M_AXI_AWVALID & M_AXI_AWREADY & last_piece. S is combinational, and S inputs are held stable by protocol.
- Each M handshake pushes {AWID, piece AWLEN} into the W FIFO.
- The piece-0 handshake pushes {AWID, piece_count-1} into the B FIFO.
- w_cmd_valid / b_cmd_valid = FIFO not empty.
- FIFO outputs are driven from storage with no combinational path from S or M.

Latency and FIFO corner cases:
- Zero-cycle latency S to M.
- A W command is visible one cycle after its M handshake.
- Simultaneous push and pop on a full FIFO is allowed; the count is unchanged.
- A pop of an empty FIFO is ignored.
- Reset mid-split discards the remaining pieces and all queued commands.

Optional Feature:
Macro: AXI_PROTOCOL_CONV_AW_OUT_REG_EN
- Defined:
  - M_AXI_AW* come from a 2-entry skid register stage; M_AXI_AWVALID resets to 0.
  - The stage is fully registered with 1 cycle added latency and full throughput.
  - A piece is "issued" (counter advance, W/B push, S_AXI_AWREADY) on acceptance into the skid stage, not on the M handshake.
- Undefined: the combinational path described above.

Test Plan:
1. AWLEN=3, INCR, ADDR=0x1000, SIZE=2 -> one M burst LEN=3, ADDR=0x1000; W cmd len 3; B cmd repeat 0; S_AXI_AWREADY same cycle as the M handshake.
2. AWLEN=0x25, INCR, ADDR=0x2004, SIZE=2 -> three M bursts: 0x2004 LEN 15; 0x2044 LEN 15; 0x2084 LEN 5. W cmds 15,15,5; B cmd repeat 2; S_AXI_AWREADY only on the 3rd.
3. AWLEN=0xFF, SIZE=3, ADDR=0xFFFFFF80 -> 16 bursts of LEN 15, address step 0x80 wrapping to 0x00000000; B cmd repeat 15.
4. WRAP, AWLEN=15, LOCK=1 -> single burst LEN 15, AWLOCK=2'b01. INCR AWLEN=31 with LOCK=1 -> two bursts, both AWLOCK=2'b00.
5. w_cmd_ready=0, depth 4, AWLEN=0x4F -> after 4 pieces M_AXI_AWVALID drops. Raising w_cmd_ready for one cycle lets the 5th piece issue.
6. ARESET asserted after piece 1 of 3 -> next cycle all valids 0, FIFOs empty. A new AWLEN=0 transaction is then handled from IDLE.

Source files
------------

// File: rtl/axi_protocol_converter_aw_axi3_split.sv
// rtl/axi_protocol_converter_aw_axi3_split.sv - AXI4 to AXI3 AW burst splitter with W/B command FIFOs
// Optional output skid stage: define AXI_PROTOCOL_CONV_AW_OUT_REG_EN
module axi_protocol_converter_aw_axi3_split #(
    parameter int C_AXI_ID_WIDTH       = 1,
    parameter int C_AXI_ADDR_WIDTH     = 32,
    parameter int C_SUPPORT_SPLITTING  = 1,
    parameter int C_CMD_FIFO_DEPTH_LOG = 2
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]                  S_AXI_AWLEN,
    input  logic [2:0]                  S_AXI_AWSIZE,
    input  logic [1:0]                  S_AXI_AWBURST,
    input  logic                        S_AXI_AWLOCK,
    input  logic [3:0]                  S_AXI_AWCACHE,
    input  logic [2:0]                  S_AXI_AWPROT,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   M_AXI_AWID,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [3:0]                  M_AXI_AWLEN,
    output logic [2:0]                  M_AXI_AWSIZE,
    output logic [1:0]                  M_AXI_AWBURST,
    output logic [1:0]                  M_AXI_AWLOCK,
    output logic [3:0]                  M_AXI_AWCACHE,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic                        w_cmd_valid,
    output logic [C_AXI_ID_WIDTH-1:0]   w_cmd_id,
    output logic [3:0]                  w_cmd_length,
    input  logic                        w_cmd_ready,
    output logic                        b_cmd_valid,
    output logic [C_AXI_ID_WIDTH-1:0]   b_cmd_id,
    output logic [3:0]                  b_cmd_repeat,
    input  logic                        b_cmd_ready
);
    localparam int IW    = C_AXI_ID_WIDTH;
    localparam int AW    = C_AXI_ADDR_WIDTH;
    localparam int LG    = C_CMD_FIFO_DEPTH_LOG;
    localparam int DEPTH = 1 << LG;
    localparam int PW    = IW + AW + 17;
    localparam logic [LG-1:0] PTR_ONE  = LG'(1);
    localparam logic [LG:0]   CNT_ONE  = (LG+1)'(1);
    localparam logic [LG:0]   CNT_FULL = (LG+1)'(DEPTH);

    typedef enum logic {IDLE, SPLIT} state_t;
    state_t state, state_next;
    logic [3:0]    piece, piece_next;
    logic [AW-1:0] next_addr, piece_addr, size_mask, step;
    logic          need_split, last_piece, piece_lock, can_issue, issue, stage_ready;
    logic [3:0]    piece_len;
    logic [PW-1:0] piece_bus;
    logic          w_full, w_empty, w_push, w_pop;
    logic          b_full, b_empty, b_push, b_pop;

    assign need_split = (C_SUPPORT_SPLITTING != 0) && (S_AXI_AWBURST == 2'b01) && (S_AXI_AWLEN[7:4] != 4'd0);
    assign last_piece = !need_split || (piece == S_AXI_AWLEN[7:4]);
    assign piece_len  = (need_split && !last_piece) ? 4'hF : S_AXI_AWLEN[3:0];
    assign piece_addr = (piece == 4'd0) ? S_AXI_AWADDR : next_addr;
    // Exclusive access cannot survive a split, so demote it to normal.
    assign piece_lock = S_AXI_AWLOCK & ~need_split;
    assign size_mask  = (AW'(1) << S_AXI_AWSIZE) - AW'(1);
    assign step       = AW'(16) << S_AXI_AWSIZE;
    assign piece_bus  = {S_AXI_AWID, piece_addr, piece_len, S_AXI_AWSIZE, S_AXI_AWBURST,
                         piece_lock, S_AXI_AWCACHE, S_AXI_AWPROT};

    assign can_issue     = S_AXI_AWVALID & ~w_full & ~((piece == 4'd0) & b_full);
    assign issue         = can_issue & stage_ready;
    assign S_AXI_AWREADY = issue & last_piece;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
            piece <= 4'd0;
        end else begin
            state <= state_next;
            piece <= piece_next;
        end
    end

    always_ff @(posedge ACLK) begin
        if (issue) next_addr <= (piece_addr & ~size_mask) + step;
    end

    always_comb begin
        state_next = state;
        piece_next = piece;
        case (state)
            IDLE: if (issue && !last_piece) begin
                state_next = SPLIT;
                piece_next = 4'd1;
            end
            SPLIT: if (issue) begin
                if (last_piece) begin
                    state_next = IDLE;
                    piece_next = 4'd0;
                end else begin
                    piece_next = piece + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                piece_next = 4'd0;
            end
        endcase
    end

`ifdef AXI_PROTOCOL_CONV_AW_OUT_REG_EN
    logic [PW-1:0] out_q, skid_q;
    logic          out_valid, skid_valid;

    assign stage_ready = ~skid_valid;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || M_AXI_AWREADY) begin
            out_valid  <= skid_valid | issue;
            skid_valid <= 1'b0;
        end else if (issue) begin
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!out_valid || M_AXI_AWREADY) begin
            if (skid_valid) out_q <= skid_q;
            else if (issue) out_q <= piece_bus;
        end else if (issue) begin
            skid_q <= piece_bus;
        end
    end

    assign M_AXI_AWVALID = out_valid;
    assign {M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
            M_AXI_AWLOCK[0], M_AXI_AWCACHE, M_AXI_AWPROT} = out_q;
`else
    assign stage_ready   = M_AXI_AWREADY;
    assign M_AXI_AWVALID = can_issue;
    assign {M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
            M_AXI_AWLOCK[0], M_AXI_AWCACHE, M_AXI_AWPROT} = piece_bus;
`endif
    assign M_AXI_AWLOCK[1] = 1'b0;

    logic [IW+3:0] w_mem [DEPTH];
    logic [LG-1:0] w_wptr, w_rptr;
    logic [LG:0]   w_count;

    assign w_full  = (w_count == CNT_FULL);
    assign w_empty = (w_count == '0);
    assign w_pop   = w_cmd_ready & ~w_empty;
    assign w_push  = issue & (~w_full | w_pop);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_wptr  <= '0;
            w_rptr  <= '0;
            w_count <= '0;
        end else begin
            if (w_push) w_wptr <= w_wptr + PTR_ONE;
            if (w_pop)  w_rptr <= w_rptr + PTR_ONE;
            if (w_push && !w_pop)      w_count <= w_count + CNT_ONE;
            else if (!w_push && w_pop) w_count <= w_count - CNT_ONE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push) w_mem[w_wptr] <= {S_AXI_AWID, piece_len};
    end

    assign w_cmd_valid              = ~w_empty;
    assign {w_cmd_id, w_cmd_length} = w_mem[w_rptr];

    logic [IW+3:0] b_mem [DEPTH];
    logic [LG-1:0] b_wptr, b_rptr;
    logic [LG:0]   b_count;

    assign b_full  = (b_count == CNT_FULL);
    assign b_empty = (b_count == '0);
    assign b_pop   = b_cmd_ready & ~b_empty;
    assign b_push  = issue & (piece == 4'd0) & (~b_full | b_pop);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            b_wptr  <= '0;
            b_rptr  <= '0;
            b_count <= '0;
        end else begin
            if (b_push) b_wptr <= b_wptr + PTR_ONE;
            if (b_pop)  b_rptr <= b_rptr + PTR_ONE;
            if (b_push && !b_pop)      b_count <= b_count + CNT_ONE;
            else if (!b_push && b_pop) b_count <= b_count - CNT_ONE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (b_push) b_mem[b_wptr] <= {S_AXI_AWID, (need_split ? S_AXI_AWLEN[7:4] : 4'd0)};
    end

    assign b_cmd_valid              = ~b_empty;
    assign {b_cmd_id, b_cmd_repeat} = b_mem[b_rptr];
endmodule

// File: tb/tb_axi_protocol_converter_aw_axi3_split.sv
// tb/tb_axi_protocol_converter_aw_axi3_split.sv - directed self-checking bench for the AW splitter
module tb_axi_protocol_converter_aw_axi3_split;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [0:0]  S_AXI_AWID;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [2:0]  S_AXI_AWSIZE;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWLOCK;
    logic [3:0]  S_AXI_AWCACHE;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [0:0]  M_AXI_AWID;
    logic [31:0] M_AXI_AWADDR;
    logic [3:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic [1:0]  M_AXI_AWLOCK;
    logic [3:0]  M_AXI_AWCACHE;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic        w_cmd_valid;
    logic [0:0]  w_cmd_id;
    logic [3:0]  w_cmd_length;
    logic        w_cmd_ready;
    logic        b_cmd_valid;
    logic [0:0]  b_cmd_id;
    logic [3:0]  b_cmd_repeat;
    logic        b_cmd_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_addr_q[$], m_len_q[$], m_lock_q[$], m_srdy_q[$];
    logic [63:0] w_len_q[$], w_id_q[$], b_rep_q[$], b_id_q[$];

    axi_protocol_converter_aw_axi3_split dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(S_AXI_AWLOCK),
        .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .w_cmd_valid(w_cmd_valid), .w_cmd_id(w_cmd_id), .w_cmd_length(w_cmd_length),
        .w_cmd_ready(w_cmd_ready),
        .b_cmd_valid(b_cmd_valid), .b_cmd_id(b_cmd_id), .b_cmd_repeat(b_cmd_repeat),
        .b_cmd_ready(b_cmd_ready)
    );

    always #5 ACLK = ~ACLK;

    // Inputs change just after rising edges, so negedge values are what the next edge sees.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                m_addr_q.push_back(64'(M_AXI_AWADDR));
                m_len_q.push_back(64'(M_AXI_AWLEN));
                m_lock_q.push_back(64'(M_AXI_AWLOCK));
                m_srdy_q.push_back(64'(S_AXI_AWREADY));
            end
            if (w_cmd_valid && w_cmd_ready) begin
                w_len_q.push_back(64'(w_cmd_length));
                w_id_q.push_back(64'(w_cmd_id));
            end
            if (b_cmd_valid && b_cmd_ready) begin
                b_rep_q.push_back(64'(b_cmd_repeat));
                b_id_q.push_back(64'(b_cmd_id));
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_m(input string tag, input logic [63:0] addr, input logic [63:0] len,
                            input logic [63:0] lock, input logic [63:0] srdy);
        if (m_addr_q.size() != 0) begin
            check({tag, "_addr"}, m_addr_q.pop_front(), addr);
            check({tag, "_len"},  m_len_q.pop_front(),  len);
            check({tag, "_lock"}, m_lock_q.pop_front(), lock);
            check({tag, "_srdy"}, m_srdy_q.pop_front(), srdy);
        end
    endtask

    task automatic expect_w(input string tag, input logic [63:0] len, input logic [63:0] id);
        if (w_len_q.size() != 0) begin
            check({tag, "_len"}, w_len_q.pop_front(), len);
            check({tag, "_id"},  w_id_q.pop_front(),  id);
        end
    endtask

    task automatic expect_b(input string tag, input logic [63:0] rep, input logic [63:0] id);
        if (b_rep_q.size() != 0) begin
            check({tag, "_rep"}, b_rep_q.pop_front(), rep);
            check({tag, "_id"},  b_id_q.pop_front(),  id);
        end
    endtask

    task automatic flush_queues();
        m_addr_q.delete(); m_len_q.delete(); m_lock_q.delete(); m_srdy_q.delete();
        w_len_q.delete(); w_id_q.delete(); b_rep_q.delete(); b_id_q.delete();
    endtask

    task automatic drive_aw(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic lock);
        S_AXI_AWID    = id;
        S_AXI_AWADDR  = addr;
        S_AXI_AWLEN   = len;
        S_AXI_AWSIZE  = size;
        S_AXI_AWBURST = burst;
        S_AXI_AWLOCK  = lock;
        S_AXI_AWVALID = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int cyc = 0;
        @(negedge ACLK);
        while (!S_AXI_AWREADY && cyc < 300) begin
            @(negedge ACLK);
            cyc++;
        end
        check({tag, "_accept_timeout"}, 64'(cyc >= 300), 64'd0);
        @(posedge ACLK);
        #1 S_AXI_AWVALID = 1'b0;
    endtask

    task automatic do_aw(input string tag, input logic [0:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                         input logic lock);
        @(posedge ACLK);
        #1 drive_aw(id, addr, len, size, burst, lock);
        wait_accept(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ARESET = 1'b1;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
        S_AXI_AWBURST = 2'b01; S_AXI_AWLOCK = 1'b0; S_AXI_AWCACHE = 4'h3; S_AXI_AWPROT = 3'h2;
        S_AXI_AWVALID = 1'b0;
        M_AXI_AWREADY = 1'b1; w_cmd_ready = 1'b1; b_cmd_ready = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_m_valid", 64'(M_AXI_AWVALID), 64'd0);
        check("rst_s_ready", 64'(S_AXI_AWREADY), 64'd0);
        check("rst_w_valid", 64'(w_cmd_valid), 64'd0);
        check("rst_b_valid", 64'(b_cmd_valid), 64'd0);
        @(posedge ACLK);
        #1 ARESET = 1'b0;

        // 1: short INCR, single burst, W command visible right after the handshake
        do_aw("t1", 1'b1, 32'h1000, 8'h03, 3'd2, 2'b01, 1'b0);
        check("t1_w_visible", 64'(w_cmd_valid), 64'd1);
        check("t1_b_visible", 64'(b_cmd_valid), 64'd1);
        repeat (4) @(posedge ACLK);
        check("t1_m_count", 64'(m_addr_q.size()), 64'd1);
        expect_m("t1_m0", 64'h1000, 64'd3, 64'd0, 64'd1);
        check("t1_w_count", 64'(w_len_q.size()), 64'd1);
        expect_w("t1_w0", 64'd3, 64'd1);
        check("t1_b_count", 64'(b_rep_q.size()), 64'd1);
        expect_b("t1_b0", 64'd0, 64'd1);

        // 2: 38 beats -> 16 + 16 + 6
        do_aw("t2", 1'b0, 32'h2004, 8'h25, 3'd2, 2'b01, 1'b0);
        repeat (4) @(posedge ACLK);
        check("t2_m_count", 64'(m_addr_q.size()), 64'd3);
        expect_m("t2_m0", 64'h2004, 64'd15, 64'd0, 64'd0);
        expect_m("t2_m1", 64'h2044, 64'd15, 64'd0, 64'd0);
        expect_m("t2_m2", 64'h2084, 64'd5,  64'd0, 64'd1);
        check("t2_w_count", 64'(w_len_q.size()), 64'd3);
        expect_w("t2_w0", 64'd15, 64'd0);
        expect_w("t2_w1", 64'd15, 64'd0);
        expect_w("t2_w2", 64'd5,  64'd0);
        check("t2_b_count", 64'(b_rep_q.size()), 64'd1);
        expect_b("t2_b0", 64'd2, 64'd0);

        // 3: 256 beats of 8 bytes, address wraps past 2^32
        do_aw("t3", 1'b1, 32'hFFFF_FF80, 8'hFF, 3'd3, 2'b01, 1'b0);
        repeat (4) @(posedge ACLK);
        check("t3_m_count", 64'(m_addr_q.size()), 64'd16);
        for (int k = 0; k < 16; k++) begin
            logic [31:0] ea;
            ea = (k == 0) ? 32'hFFFF_FF80 : 32'((k - 1) * 32'h80);
            expect_m($sformatf("t3_m%0d", k), 64'(ea), 64'd15, 64'd0, 64'(k == 15));
            expect_w($sformatf("t3_w%0d", k), 64'd15, 64'd1);
        end
        check("t3_b_count", 64'(b_rep_q.size()), 64'd1);
        expect_b("t3_b0", 64'd15, 64'd1);

        // 4: WRAP keeps exclusive; split INCR demotes it
        do_aw("t4a", 1'b0, 32'h3000, 8'h0F, 3'd2, 2'b10, 1'b1);
        do_aw("t4b", 1'b0, 32'h4000, 8'h1F, 3'd2, 2'b01, 1'b1);
        repeat (4) @(posedge ACLK);
        check("t4_m_count", 64'(m_addr_q.size()), 64'd3);
        expect_m("t4a_m0", 64'h3000, 64'd15, 64'd1, 64'd1);
        expect_m("t4b_m0", 64'h4000, 64'd15, 64'd0, 64'd0);
        expect_m("t4b_m1", 64'h4040, 64'd15, 64'd0, 64'd1);
        check("t4_b_count", 64'(b_rep_q.size()), 64'd2);
        expect_b("t4a_b0", 64'd0, 64'd0);
        expect_b("t4b_b0", 64'd1, 64'd0);
        flush_queues();

        // 5: W FIFO fills after 4 pieces, one pop releases the 5th
        w_cmd_ready = 1'b0;
        @(posedge ACLK);
        #1 drive_aw(1'b1, 32'h5000, 8'h4F, 3'd2, 2'b01, 1'b0);
        repeat (8) @(posedge ACLK);
        @(negedge ACLK);
        check("t5_m_count_stalled", 64'(m_addr_q.size()), 64'd4);
        check("t5_m_valid_low", 64'(M_AXI_AWVALID), 64'd0);
        check("t5_s_ready_low", 64'(S_AXI_AWREADY), 64'd0);
        @(posedge ACLK);
        #1 w_cmd_ready = 1'b1;
        @(posedge ACLK);
        #1 w_cmd_ready = 1'b0;
        wait_accept("t5");
        check("t5_m_count", 64'(m_addr_q.size()), 64'd5);
        w_cmd_ready = 1'b1;
        repeat (8) @(posedge ACLK);
        for (int k = 0; k < 5; k++) begin
            expect_m($sformatf("t5_m%0d", k), 64'(32'h5000 + k * 32'h40), 64'd15, 64'd0, 64'(k == 4));
        end
        check("t5_w_count", 64'(w_len_q.size()), 64'd5);
        for (int k = 0; k < 5; k++) expect_w($sformatf("t5_w%0d", k), 64'd15, 64'd1);
        check("t5_b_count", 64'(b_rep_q.size()), 64'd1);
        expect_b("t5_b0", 64'd4, 64'd1);
        flush_queues();

        // 6: reset mid-split drops queued commands and the remaining pieces
        w_cmd_ready = 1'b0;
        b_cmd_ready = 1'b0;
        @(posedge ACLK);
        #1 drive_aw(1'b0, 32'h6000, 8'h25, 3'd2, 2'b01, 1'b0);
        @(posedge ACLK);
        #1;
        check("t6_w_queued", 64'(w_cmd_valid), 64'd1);
        ARESET = 1'b1;
        S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        check("t6_rst_m_valid", 64'(M_AXI_AWVALID), 64'd0);
        check("t6_rst_s_ready", 64'(S_AXI_AWREADY), 64'd0);
        check("t6_rst_w_valid", 64'(w_cmd_valid), 64'd0);
        check("t6_rst_b_valid", 64'(b_cmd_valid), 64'd0);
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        flush_queues();
        w_cmd_ready = 1'b1;
        b_cmd_ready = 1'b1;
        do_aw("t6", 1'b1, 32'h7000, 8'h00, 3'd2, 2'b01, 1'b0);
        repeat (4) @(posedge ACLK);
        check("t6_m_count", 64'(m_addr_q.size()), 64'd1);
        expect_m("t6_m0", 64'h7000, 64'd0, 64'd0, 64'd1);
        check("t6_w_count", 64'(w_len_q.size()), 64'd1);
        expect_w("t6_w0", 64'd0, 64'd1);
        check("t6_b_count", 64'(b_rep_q.size()), 64'd1);
        expect_b("t6_b0", 64'd0, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
